conv_loop_sequencer: RTL and testbench

CONV_LOOP_SEQUENCER -- requirements
Module: conv_loop_sequencer

---
 rtl/conv_loop_sequencer_if.sv | 47 ++++
 rtl/conv_loop_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_conv_loop_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_loop_sequencer_if.sv
// Handshake and result bus of the convolution loop sequencer.
//   start/abort      : layer control from the host
//   running/done     : layer status back to the host
//   con_valid/ready  : upstream word stream handshake
//   load_k_sel, load_i_sel, load_i_en, i_shift, compute_en : datapath strobes
//   out_ready/output_* : downstream result coordinate handshake
// The sequencer connects through the master modport and its environment through the slave modport.
interface conv_loop_sequencer_if #(
    parameter int unsigned KERNEL_WORDS = 12,
    parameter int unsigned INPUT_WORDS  = 4,
    parameter int unsigned CH_PER_GROUP = 6
);
    localparam int unsigned ISEL_W = (INPUT_WORDS > 1) ? $clog2(INPUT_WORDS) : 1;
    localparam int unsigned NCH_W  = $clog2(CH_PER_GROUP + 1);

    logic                    start;
    logic                    abort;
    logic                    running;
    logic                    done;
    logic                    con_valid;
    logic                    con_ready;
    logic [KERNEL_WORDS-1:0] load_k_sel;
    logic [ISEL_W-1:0]       load_i_sel;
    logic                    load_i_en;
    logic                    i_shift;
    logic                    compute_en;
    logic                    out_ready;
    logic                    output_valid;
    logic [31:0]             output_x;
    logic [31:0]             output_y;
    logic [31:0]             output_ch;
    logic [NCH_W-1:0]        output_nch;

    modport master (
        input  start, abort, con_valid, out_ready,
        output running, done, con_ready, load_k_sel, load_i_sel, load_i_en,
               i_shift, compute_en, output_valid, output_x, output_y,
               output_ch, output_nch
    );

    modport slave (
        output start, abort, con_valid, out_ready,
        input  running, done, con_ready, load_k_sel, load_i_sel, load_i_en,
               i_shift, compute_en, output_valid, output_x, output_y,
               output_ch, output_nch
    );
endinterface

// File: rtl/conv_loop_sequencer.sv
// Convolution loop sequencer: walks output-channel groups, rows and x positions,
// steering kernel/input word loads from one upstream stream and issuing compute
// passes. Each pass at x>0 publishes the coordinate of the previous position,
// and a drain pass publishes the last column of the row.
// Ports:
//   clk, arst_n_in : clock, asynchronous active-low reset
//   bus (master)   : control, word stream, datapath strobes and result bus
// State, counters and the result register are flops; the strobes and
// con_ready are decoded from the state and the current handshake inputs.
module conv_loop_sequencer #(
    parameter int unsigned FEATURE_MAP_WIDTH  = 64,
    parameter int unsigned FEATURE_MAP_HEIGHT = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 32,
    parameter int unsigned CH_PER_GROUP       = 6,
    parameter int unsigned KERNEL_WORDS       = 12,
    parameter int unsigned K_LOADS            = 6,
    parameter int unsigned INPUT_WORDS        = 4,
    parameter int unsigned I_LOADS            = 3,
    parameter int unsigned COMPUTE_CYCLES     = 6
) (
    input  logic clk,
    input  logic arst_n_in,
    conv_loop_sequencer_if.master bus
);
    localparam int unsigned NGRP = (OUTPUT_NB_CHANNELS + CH_PER_GROUP - 1) / CH_PER_GROUP;
    localparam int unsigned XW   = (FEATURE_MAP_WIDTH > 1)  ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int unsigned YW   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int unsigned GW   = (NGRP > 1)               ? $clog2(NGRP)               : 1;
    localparam int unsigned KWW  = (KERNEL_WORDS > 1)       ? $clog2(KERNEL_WORDS)       : 1;
    localparam int unsigned KBW  = (K_LOADS > 1)            ? $clog2(K_LOADS)            : 1;
    localparam int unsigned IWW  = (INPUT_WORDS > 1)        ? $clog2(INPUT_WORDS)        : 1;
    localparam int unsigned IBW  = (I_LOADS > 1)            ? $clog2(I_LOADS)            : 1;
    localparam int unsigned CYW  = (COMPUTE_CYCLES > 1)     ? $clog2(COMPUTE_CYCLES)     : 1;
    localparam int unsigned NCHW = $clog2(CH_PER_GROUP + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_K  = 3'd1;
    localparam logic [2:0] S_LOAD_I  = 3'd2;
    localparam logic [2:0] S_SHIFT_I = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]      r_state, w_state_nxt;
    logic [XW-1:0]   r_x,     w_x_nxt;
    logic [YW-1:0]   r_y,     w_y_nxt;
    logic [GW-1:0]   r_grp,   w_grp_nxt;
    logic [KWW-1:0]  r_kw,    w_kw_nxt;
    logic [KBW-1:0]  r_kb,    w_kb_nxt;
    logic [IWW-1:0]  r_iw,    w_iw_nxt;
    logic [IBW-1:0]  r_ib,    w_ib_nxt;
    logic [CYW-1:0]  r_cyc,   w_cyc_nxt;
    logic            r_ov,    w_ov_nxt;
    logic [31:0]     r_ox,    w_ox_nxt;
    logic [31:0]     r_oy,    w_oy_nxt;
    logic [31:0]     r_och,   w_och_nxt;
    logic [NCHW-1:0] r_onch,  w_onch_nxt;
    logic            r_done,  w_done_nxt;

    logic [31:0]             w_base;
    logic [31:0]             w_rem;
    logic [NCHW-1:0]         w_nch;
    logic                    w_last;
    logic                    w_stall;
    logic                    w_word;
    logic                    w_adv;
    logic                    w_emit;
    logic [31:0]             w_emit_x;
    logic                    w_con_ready;
    logic [KERNEL_WORDS-1:0] w_load_k_sel;
    logic [IWW-1:0]          w_load_i_sel;
    logic                    w_load_i_en;
    logic                    w_i_shift;
    logic                    w_compute_en;

    // Channel window of the current group; the last group may be partial.
    assign w_base = 32'(r_grp) * 32'(CH_PER_GROUP);
    assign w_rem  = 32'(OUTPUT_NB_CHANNELS) - w_base;
    assign w_nch  = (w_rem < 32'(CH_PER_GROUP)) ? NCHW'(w_rem) : NCHW'(CH_PER_GROUP);

    // Last pass/drain cycle cannot retire while an unaccepted result is still held.
    assign w_last  = (r_cyc == CYW'(COMPUTE_CYCLES - 1));
    assign w_stall = w_last && r_ov && !bus.out_ready;
    assign w_word  = (32'(r_cyc) < INPUT_WORDS);

    // Next-state, counter and strobe decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_grp_nxt    = r_grp;
        w_kw_nxt     = r_kw;
        w_kb_nxt     = r_kb;
        w_iw_nxt     = r_iw;
        w_ib_nxt     = r_ib;
        w_cyc_nxt    = r_cyc;
        w_done_nxt   = 1'b0;
        w_adv        = 1'b0;
        w_emit       = 1'b0;
        w_emit_x     = '0;
        w_con_ready  = 1'b0;
        w_load_k_sel = '0;
        w_load_i_sel = '0;
        w_load_i_en  = 1'b0;
        w_i_shift    = 1'b0;
        w_compute_en = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_grp_nxt   = '0;
                    w_kw_nxt    = '0;
                    w_kb_nxt    = '0;
                    w_iw_nxt    = '0;
                    w_ib_nxt    = '0;
                    w_cyc_nxt   = '0;
                    w_state_nxt = S_LOAD_K;
                end
            end
            S_LOAD_K: begin
                w_con_ready = 1'b1;
                if (bus.con_valid) begin
                    w_load_k_sel = KERNEL_WORDS'(1) << r_kw;
                    if (r_kw == KWW'(KERNEL_WORDS - 1)) begin
                        w_kw_nxt = '0;
                        if (r_kb == KBW'(K_LOADS - 1)) begin
                            w_kb_nxt    = '0;
                            w_state_nxt = S_LOAD_I;
                        end else begin
                            w_kb_nxt = r_kb + KBW'(1);
                        end
                    end else begin
                        w_kw_nxt = r_kw + KWW'(1);
                    end
                end
            end
            S_LOAD_I: begin
                w_con_ready  = 1'b1;
                w_load_i_sel = r_iw;
                if (bus.con_valid) begin
                    w_load_i_en = 1'b1;
                    if (r_iw == IWW'(INPUT_WORDS - 1)) begin
                        w_iw_nxt    = '0;
                        w_state_nxt = S_SHIFT_I;
                    end else begin
                        w_iw_nxt = r_iw + IWW'(1);
                    end
                end
            end
            S_SHIFT_I: begin
                w_i_shift = 1'b1;
                if (r_ib == IBW'(I_LOADS - 1)) begin
                    w_ib_nxt    = '0;
                    w_cyc_nxt   = '0;
                    w_state_nxt = S_COMPUTE;
                end else begin
                    w_ib_nxt    = r_ib + IBW'(1);
                    w_state_nxt = S_LOAD_I;
                end
            end
            S_COMPUTE: begin
                // Word-consuming cycles only advance on a transfer.
                if (w_word) begin
                    w_con_ready  = !w_stall;
                    w_load_i_sel = IWW'(r_cyc);
                    w_adv        = bus.con_valid && !w_stall;
                    w_load_i_en  = w_adv;
                end else begin
                    w_adv = !w_stall;
                end
                w_compute_en = w_adv;
                w_i_shift    = w_adv && w_last;
                if (w_adv) begin
                    if (w_last) begin
                        w_cyc_nxt = '0;
                        if (r_x != '0) begin
                            w_emit   = 1'b1;
                            w_emit_x = 32'(r_x) - 32'd1;
                        end
                        if (r_x == XW'(FEATURE_MAP_WIDTH - 1)) begin
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_x_nxt = r_x + XW'(1);
                        end
                    end else begin
                        w_cyc_nxt = r_cyc + CYW'(1);
                    end
                end
            end
            S_DRAIN: begin
                w_adv        = !w_stall;
                w_compute_en = w_adv;
                if (w_adv) begin
                    if (w_last) begin
                        w_cyc_nxt = '0;
                        w_emit    = 1'b1;
                        w_emit_x  = 32'(FEATURE_MAP_WIDTH - 1);
                        w_x_nxt   = '0;
                        if (r_y != YW'(FEATURE_MAP_HEIGHT - 1)) begin
                            w_y_nxt     = r_y + YW'(1);
                            w_state_nxt = S_LOAD_I;
                        end else if (r_grp != GW'(NGRP - 1)) begin
                            w_grp_nxt   = r_grp + GW'(1);
                            w_y_nxt     = '0;
                            w_state_nxt = S_LOAD_K;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_cyc_nxt = r_cyc + CYW'(1);
                    end
                end
            end
            S_DONE: begin
                if (!r_ov) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Result register: a pop clears, a load in the same cycle wins.
        w_ov_nxt   = r_ov && !bus.out_ready;
        w_ox_nxt   = r_ox;
        w_oy_nxt   = r_oy;
        w_och_nxt  = r_och;
        w_onch_nxt = r_onch;
        if (w_emit) begin
            w_ov_nxt   = 1'b1;
            w_ox_nxt   = w_emit_x;
            w_oy_nxt   = 32'(r_y);
            w_och_nxt  = w_base;
            w_onch_nxt = w_nch;
        end

        // Abort overrides every transition and suppresses the done pulse.
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_grp_nxt   = '0;
            w_kw_nxt    = '0;
            w_kb_nxt    = '0;
            w_iw_nxt    = '0;
            w_ib_nxt    = '0;
            w_cyc_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_ov_nxt    = 1'b0;
            w_ox_nxt    = '0;
            w_oy_nxt    = '0;
            w_och_nxt   = '0;
            w_onch_nxt  = '0;
        end
    end

    // State, counters and result register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_grp   <= '0;
            r_kw    <= '0;
            r_kb    <= '0;
            r_iw    <= '0;
            r_ib    <= '0;
            r_cyc   <= '0;
            r_ov    <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_och   <= '0;
            r_onch  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_grp   <= w_grp_nxt;
            r_kw    <= w_kw_nxt;
            r_kb    <= w_kb_nxt;
            r_iw    <= w_iw_nxt;
            r_ib    <= w_ib_nxt;
            r_cyc   <= w_cyc_nxt;
            r_ov    <= w_ov_nxt;
            r_ox    <= w_ox_nxt;
            r_oy    <= w_oy_nxt;
            r_och   <= w_och_nxt;
            r_onch  <= w_onch_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.running      = (r_state != S_IDLE);
    assign bus.done         = r_done;
    assign bus.con_ready    = w_con_ready;
    assign bus.load_k_sel   = w_load_k_sel;
    assign bus.load_i_sel   = w_load_i_sel;
    assign bus.load_i_en    = w_load_i_en;
    assign bus.i_shift      = w_i_shift;
    assign bus.compute_en   = w_compute_en;
    assign bus.output_valid = r_ov;
    assign bus.output_x     = r_ox;
    assign bus.output_y     = r_oy;
    assign bus.output_ch    = r_och;
    assign bus.output_nch   = r_onch;
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Self-checking bench for conv_loop_sequencer on a small 4x2 map, 8 channels in groups of 6.
module tb_conv_loop_sequencer;
    localparam int unsigned W = 4, H = 2, OC = 8, CPG = 6, KW = 2, KL = 1, IW = 2, IL = 1, CC = 3;
    localparam int NBEATS = 16;

    logic clk = 1'b0;
    logic arst_n_in;

    conv_loop_sequencer_if #(.KERNEL_WORDS(KW), .INPUT_WORDS(IW), .CH_PER_GROUP(CPG)) bus ();

    conv_loop_sequencer #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC),
        .CH_PER_GROUP(CPG), .KERNEL_WORDS(KW), .K_LOADS(KL), .INPUT_WORDS(IW),
        .I_LOADS(IL), .COMPUTE_CYCLES(CC)
    ) dut (
        .clk(clk),
        .arst_n_in(arst_n_in),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int ch; int nch; } beat_t;
    typedef struct {
        string name;
        bit    cv_tog;
        int    bp_len;
        int    start_at;
        int    exp_beats;
        int    exp_k;
        int    exp_ie;
        int    exp_ce;
        int    exp_sh;
        int    exp_done;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    beat_t          exp_beats [NBEATS];
    beat_t          got [$];
    logic [KW-1:0]  kseq [$];
    int n_k, n_ie, n_ce, n_sh, n_done, n_viol;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one layer from IDLE. abort_after/rst_after >= 0 cut the run short once
    // that many beats have been accepted (abort applied for one cycle, or an async reset pulse).
    task automatic run_layer(input bit cv_tog, input int bp_len, input int start_at,
                             input int abort_after, input int rst_after);
        bit    bp_on      = 1'b0;
        int    bp_cnt     = 0;
        bit    abort_sent = 1'b0;
        int    tail       = -1;
        beat_t b;
        got.delete();
        kseq.delete();
        n_k = 0; n_ie = 0; n_ce = 0; n_sh = 0; n_done = 0; n_viol = 0;
        for (int c = 0; c < 3000 && tail != 0; c++) begin
            @(negedge clk);
            bus.start     = (c == 0) || (c == start_at);
            bus.abort     = 1'b0;
            bus.con_valid = cv_tog ? (c % 2 == 0) : 1'b1;
            if (bp_len > 0 && !bp_on && bus.output_valid) bp_on = 1'b1;
            bus.out_ready = !(bp_on && bp_cnt < bp_len);
            if (abort_sent) begin
                #1;
                chk("abort_running", bus.running, 0);
                chk("abort_output_valid", bus.output_valid, 0);
                chk("abort_con_ready", bus.con_ready, 0);
                return;
            end
            if (abort_after >= 0 && got.size() >= abort_after) begin
                bus.abort  = 1'b1;
                abort_sent = 1'b1;
            end
            #1;
            if (rst_after >= 0 && got.size() >= rst_after) begin
                arst_n_in = 1'b0;
                #1;
                chk("rst_running", bus.running, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_con_ready", bus.con_ready, 0);
                chk("rst_load_k_sel", bus.load_k_sel, 0);
                chk("rst_load_i_en", bus.load_i_en, 0);
                chk("rst_i_shift", bus.i_shift, 0);
                chk("rst_compute_en", bus.compute_en, 0);
                chk("rst_output_valid", bus.output_valid, 0);
                chk("rst_output_x", bus.output_x, 0);
                chk("rst_output_y", bus.output_y, 0);
                chk("rst_output_ch", bus.output_ch, 0);
                chk("rst_output_nch", bus.output_nch, 0);
                #1 arst_n_in = 1'b1;
                return;
            end
            if (bus.load_k_sel != '0) begin
                n_k++;
                kseq.push_back(bus.load_k_sel);
                if (!(bus.con_valid && bus.con_ready)) n_viol++;
            end
            if (bus.load_i_en) begin
                n_ie++;
                if (!(bus.con_valid && bus.con_ready)) n_viol++;
            end
            if (bus.compute_en) n_ce++;
            if (bus.i_shift) n_sh++;
            if (bp_on && bp_cnt < bp_len) begin
                bp_cnt++;
                chk("bp_hold_valid", bus.output_valid, 1);
                chk("bp_hold_x", bus.output_x, 0);
                chk("bp_hold_y", bus.output_y, 0);
                chk("bp_hold_ch", bus.output_ch, 0);
                if (bp_cnt >= 3) begin
                    chk("bp_freeze_compute_en", bus.compute_en, 0);
                    chk("bp_freeze_i_shift", bus.i_shift, 0);
                end
            end
            if (bus.output_valid && bus.out_ready) begin
                b.x   = int'(bus.output_x);
                b.y   = int'(bus.output_y);
                b.ch  = int'(bus.output_ch);
                b.nch = int'(bus.output_nch);
                got.push_back(b);
            end
            if (bus.done) begin
                n_done++;
                chk("done_running_low", bus.running, 0);
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
        end
        if (n_done == 0) begin
            checks++;
            failures++;
            $display("FAIL layer_timeout: got no done pulse, required one within 3000 cycles");
        end
    endtask

    task automatic cmp_beats(input string tag, input int n);
        chk({tag, "_beat_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            if (got[i] != exp_beats[i]) begin
                checks++;
                failures++;
                $display("FAIL %s_beat%0d: got (x%0d,y%0d,ch%0d,n%0d) expected (x%0d,y%0d,ch%0d,n%0d)",
                         tag, i, got[i].x, got[i].y, got[i].ch, got[i].nch,
                         exp_beats[i].x, exp_beats[i].y, exp_beats[i].ch, exp_beats[i].nch);
            end else begin
                checks++;
            end
        end
    endtask

    vec_t vecs [4];

    initial begin
        exp_beats = '{'{0,0,0,6}, '{1,0,0,6}, '{2,0,0,6}, '{3,0,0,6},
                      '{0,1,0,6}, '{1,1,0,6}, '{2,1,0,6}, '{3,1,0,6},
                      '{0,0,6,2}, '{1,0,6,2}, '{2,0,6,2}, '{3,0,6,2},
                      '{0,1,6,2}, '{1,1,6,2}, '{2,1,6,2}, '{3,1,6,2}};
        //          name             tog bp  start beats k  ie  ce  sh done
        vecs[0] = '{"nominal",        0,  0,  -1,  16,  4, 40, 60, 20, 1};
        vecs[1] = '{"valid_toggle",   1,  0,  -1,  16,  4, 40, 60, 20, 1};
        vecs[2] = '{"backpressure",   0, 10,  -1,  16,  4, 40, 60, 20, 1};
        vecs[3] = '{"start_ignored",  1,  0,  30,  16,  4, 40, 60, 20, 1};

        arst_n_in     = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.con_valid = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("reset_running", bus.running, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_con_ready", bus.con_ready, 0);
        chk("reset_load_k_sel", bus.load_k_sel, 0);
        chk("reset_load_i_en", bus.load_i_en, 0);
        chk("reset_i_shift", bus.i_shift, 0);
        chk("reset_compute_en", bus.compute_en, 0);
        chk("reset_output_valid", bus.output_valid, 0);
        chk("reset_output_x", bus.output_x, 0);
        chk("reset_output_y", bus.output_y, 0);
        chk("reset_output_ch", bus.output_ch, 0);
        chk("reset_output_nch", bus.output_nch, 0);
        @(negedge clk);
        arst_n_in = 1'b1;
        bus.con_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("idle_without_start", bus.running, 0);
        end

        for (int v = 0; v < 4; v++) begin
            run_layer(vecs[v].cv_tog, vecs[v].bp_len, vecs[v].start_at, -1, -1);
            cmp_beats(vecs[v].name, vecs[v].exp_beats);
            chk({vecs[v].name, "_k_strobes"}, n_k, vecs[v].exp_k);
            chk({vecs[v].name, "_i_loads"}, n_ie, vecs[v].exp_ie);
            chk({vecs[v].name, "_compute_en"}, n_ce, vecs[v].exp_ce);
            chk({vecs[v].name, "_i_shift"}, n_sh, vecs[v].exp_sh);
            chk({vecs[v].name, "_done_pulses"}, n_done, vecs[v].exp_done);
            chk({vecs[v].name, "_strobe_without_transfer"}, n_viol, 0);
            for (int i = 0; i < kseq.size(); i++)
                chk({vecs[v].name, "_k_sel_order"}, kseq[i], (i % 2 == 0) ? 1 : 2);
        end

        // Abort while the pass at x=2 is in flight, then a clean rerun.
        run_layer(1'b0, 0, -1, 1, -1);
        chk("abort_beats_before", got.size(), 1);
        run_layer(1'b0, 0, -1, -1, -1);
        cmp_beats("after_abort", NBEATS);
        chk("after_abort_done_pulses", n_done, 1);

        // Async reset in the middle of the row-0 drain, then a clean rerun.
        run_layer(1'b0, 0, -1, -1, 3);
        chk("rst_beats_before", got.size(), 3);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("post_reset_idle", bus.running, 0);
        end
        run_layer(1'b0, 0, -1, -1, -1);
        cmp_beats("after_reset", NBEATS);
        chk("after_reset_done_pulses", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
